// File: rtl/video_timing_gen_win.sv
// Raster timing generator with a runtime-placed frame-buffer window on a background colour.
// Optional colour-bar test pattern is built when VTG_TEST_PATTERN_EN is defined.
module video_timing_gen_win #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned REQ_LEAD = 1,
  parameter int unsigned CNT_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  i_start_x,
  input  logic [CNT_W-1:0]  i_start_y,
  input  logic [CNT_W-1:0]  i_disp_h,
  input  logic [CNT_W-1:0]  i_disp_v,
  input  logic [DATA_W-1:0] i_bg_color,
`ifdef VTG_TEST_PATTERN_EN
  input  logic              i_pattern_sel,
`endif
  input  logic              i_video_can_read,
  input  logic [DATA_W-1:0] i_rgb,
  output logic              o_data_req,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_de,
  output logic [DATA_W-1:0] o_rgb,
  output logic              o_frame_start,
  output logic              o_underflow
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       win;
    logic       fs;
    logic       tag;
`ifdef VTG_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
  } tap_t;

  logic [CNT_W-1:0]  h_cnt, v_cnt, h_nxt_c;
  logic              h_last_c, v_last_c;
  logic [CNT_W-1:0]  sx, sy, dh, dv;
  logic [DATA_W-1:0] bg;
  logic [CNT_W:0]    x_end_c, y_end_c;
  logic              act_c, win_c, hs_c, vs_c, fs_c;
  tap_t              s0, head_c, tail_c;
  logic [DATA_W-1:0] pix_c;

  assign h_last_c = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last_c = (v_cnt == CNT_W'(V_TOTAL - 1));
  assign h_nxt_c  = h_last_c ? '0 : h_cnt + CNT_W'(1);

  // Raster position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt_c;
      if (h_last_c) v_cnt <= v_last_c ? '0 : v_cnt + CNT_W'(1);
    end
  end

`ifdef VTG_TEST_PATTERN_EN
  logic pat;
`endif

  // Geometry shadows load on the edge that enters (0,0), so the new frame sees them whole
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx <= '0;
      sy <= '0;
      dh <= '0;
      dv <= '0;
      bg <= '0;
`ifdef VTG_TEST_PATTERN_EN
      pat <= 1'b0;
`endif
    end else if (h_last_c && v_last_c) begin
      sx <= i_start_x;
      sy <= i_start_y;
      dh <= i_disp_h;
      dv <= i_disp_v;
      bg <= i_bg_color;
`ifdef VTG_TEST_PATTERN_EN
      pat <= i_pattern_sel;
`endif
    end
  end

  assign x_end_c = {1'b0, sx} + {1'b0, dh};
  assign y_end_c = {1'b0, sy} + {1'b0, dv};
  assign act_c   = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  assign win_c   = act_c && (h_cnt >= sx) && ({1'b0, h_cnt} < x_end_c)
                         && (v_cnt >= sy) && ({1'b0, v_cnt} < y_end_c);
  assign hs_c    = (h_cnt >= CNT_W'(HS_BEG)) && (h_cnt < CNT_W'(HS_END));
  assign vs_c    = (v_cnt >= CNT_W'(VS_BEG)) && (v_cnt < CNT_W'(VS_END));
  assign fs_c    = (h_cnt == '0) && (v_cnt == '0);

`ifdef VTG_TEST_PATTERN_EN
  // Bar index tracked as quotient/remainder of (h-start_x)*8 over disp_h
  logic [3:0]       bar;
  logic [CNT_W-1:0] rem;
  logic [CNT_W:0]   sum_c;
  logic [CNT_W+3:0] sub_c;
  logic [3:0]       step_c;

  always_comb begin
    sum_c  = {1'b0, rem} + (CNT_W+1)'(8);
    sub_c  = '0;
    step_c = '0;
    for (int k = 1; k <= 8; k++) begin
      if ({3'b0, sum_c} >= (CNT_W+4)'(k) * {4'b0, dh}) begin
        step_c = 4'(k);
        sub_c  = (CNT_W+4)'(k) * {4'b0, dh};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar <= '0;
      rem <= '0;
    end else if (h_nxt_c <= sx) begin
      bar <= '0;
      rem <= '0;
    end else if (!bar[3] && (dh != '0)) begin
      bar <= bar + step_c;
      rem <= CNT_W'({3'b0, sum_c} - sub_c);
    end
  end
`endif

  // Request stage: o_data_req marks the cycle a pixel is asked of the frame buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0         <= '0;
      o_data_req <= 1'b0;
    end else begin
      s0.hs  <= hs_c;
      s0.vs  <= vs_c;
      s0.de  <= act_c;
      s0.win <= win_c;
      s0.fs  <= fs_c;
      s0.tag <= 1'b0;
`ifdef VTG_TEST_PATTERN_EN
      s0.bar     <= bar[2:0];
      o_data_req <= win_c & ~pat;
`else
      o_data_req <= win_c;
`endif
    end
  end

  always_comb begin
    head_c     = s0;
    head_c.tag = o_data_req & ~i_video_can_read;
  end

  generate
    if (REQ_LEAD == 0) begin : g_no_dly
      assign tail_c = head_c;
    end else begin : g_dly
      tap_t dly [REQ_LEAD];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < int'(REQ_LEAD); i++) dly[i] <= '0;
        end else begin
          dly[0] <= head_c;
          for (int i = 1; i < int'(REQ_LEAD); i++) dly[i] <= dly[i-1];
        end
      end
      assign tail_c = dly[REQ_LEAD-1];
    end
  endgenerate

`ifdef VTG_TEST_PATTERN_EN
  localparam int unsigned CH_W = DATA_W / 3;
  logic [2:0]        rgb3_c;
  logic [DATA_W-1:0] bar_rgb_c;

  always_comb begin
    rgb3_c = 3'b000;
    case (tail_c.bar)
      3'd0:    rgb3_c = 3'b111;
      3'd1:    rgb3_c = 3'b110;
      3'd2:    rgb3_c = 3'b011;
      3'd3:    rgb3_c = 3'b010;
      3'd4:    rgb3_c = 3'b101;
      3'd5:    rgb3_c = 3'b100;
      3'd6:    rgb3_c = 3'b001;
      default: rgb3_c = 3'b000;
    endcase
    bar_rgb_c = DATA_W'({{CH_W{rgb3_c[2]}}, {CH_W{rgb3_c[1]}}, {CH_W{rgb3_c[0]}}});
  end
`endif

  // Pixel source: frame buffer inside the window unless its read underflowed
  always_comb begin
    pix_c = '0;
    if (tail_c.de) begin
      pix_c = bg;
      if (tail_c.win && !tail_c.tag) pix_c = i_rgb;
`ifdef VTG_TEST_PATTERN_EN
      if (tail_c.win && pat) pix_c = bar_rgb_c;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_hs          <= ~HS_POL;
      o_vs          <= ~VS_POL;
      o_de          <= 1'b0;
      o_rgb         <= '0;
      o_frame_start <= 1'b0;
      o_underflow   <= 1'b0;
    end else begin
      o_hs          <= tail_c.hs ? HS_POL : ~HS_POL;
      o_vs          <= tail_c.vs ? VS_POL : ~VS_POL;
      o_de          <= tail_c.de;
      o_rgb         <= pix_c;
      o_frame_start <= tail_c.fs;
      o_underflow   <= tail_c.fs ? tail_c.tag : (o_underflow | tail_c.tag);
    end
  end

endmodule

// File: tb/tb_video_timing_gen_win.sv
// Directed bench for video_timing_gen_win on a small 24x12 raster with a 3-clock read lead.
module tb_video_timing_gen_win;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned LEAD   = 3;
  localparam int          FRAME  = 288;
  localparam logic [DATA_W-1:0] BG = 24'hA5A5A5;

  logic              clk, rst;
  logic [CNT_W-1:0]  i_start_x, i_start_y, i_disp_h, i_disp_v;
  logic [DATA_W-1:0] i_bg_color, i_rgb;
  logic              i_video_can_read;
`ifdef VTG_TEST_PATTERN_EN
  logic              i_pattern_sel;
`endif
  logic              o_data_req, o_hs, o_vs, o_de, o_frame_start, o_underflow;
  logic [DATA_W-1:0] o_rgb;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [CNT_W-1:0] sx, sy, dh, dv;
    int req, de, bgpix, hs, vs, blank;
  } vec_t;
  vec_t tbl [8];

  video_timing_gen_win #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .DATA_W(DATA_W), .REQ_LEAD(LEAD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .i_start_x(i_start_x), .i_start_y(i_start_y),
    .i_disp_h(i_disp_h), .i_disp_v(i_disp_v),
    .i_bg_color(i_bg_color),
`ifdef VTG_TEST_PATTERN_EN
    .i_pattern_sel(i_pattern_sel),
`endif
    .i_video_can_read(i_video_can_read), .i_rgb(i_rgb),
    .o_data_req(o_data_req), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
    .o_rgb(o_rgb), .o_frame_start(o_frame_start), .o_underflow(o_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame-buffer data is the cycle number, so any sample identifies its cycle
  initial begin
    i_rgb = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      i_rgb = DATA_W'(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply(input int sx, input int sy, input int dh, input int dv);
    i_start_x = CNT_W'(sx);
    i_start_y = CNT_W'(sy);
    i_disp_h  = CNT_W'(dh);
    i_disp_v  = CNT_W'(dv);
  endtask

  task automatic wait_fs();
    bit ok;
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (o_frame_start) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("frame_start_timeout", 32'(ok), 32'd1);
  endtask

  // Counts over one frame period starting at the current sample
  task automatic count_frame(output int n_req, output int n_de, output int n_bg,
                             output int n_hs, output int n_vs, output int n_blank);
    n_req = 0; n_de = 0; n_bg = 0; n_hs = 0; n_vs = 0; n_blank = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i != 0) @(negedge clk);
      n_req += int'(o_data_req);
      n_de  += int'(o_de);
      n_hs  += int'(o_hs);
      n_vs  += int'(o_vs);
      if (o_de && (o_rgb == BG)) n_bg++;
      if (!o_de && (o_rgb != '0)) n_blank++;
    end
  endtask

  initial begin
    int n_req, n_de, n_bg, n_hs, n_vs, n_blank;
    int first, run, drops, hs_t1, hs_w, hs_p;
    bit found, stop;
    string nm;

    tbl[0] = '{12'd0,  12'd0, 12'd0,  12'd0, 0,   128, 128, 36, 48, 0};
    tbl[1] = '{12'd4,  12'd2, 12'd6,  12'd3, 18,  128, 110, 36, 48, 0};
    tbl[2] = '{12'd12, 12'd0, 12'd10, 12'd8, 32,  128, 96,  36, 48, 0};
    tbl[3] = '{12'd0,  12'd6, 12'd16, 12'd5, 32,  128, 96,  36, 48, 0};
    tbl[4] = '{12'd3,  12'd3, 12'd5,  12'd0, 0,   128, 128, 36, 48, 0};
    tbl[5] = '{12'd0,  12'd0, 12'd16, 12'd8, 128, 128, 0,   36, 48, 0};
    tbl[6] = '{12'd15, 12'd7, 12'd1,  12'd1, 1,   128, 127, 36, 48, 0};
    tbl[7] = '{12'd16, 12'd0, 12'd4,  12'd8, 0,   128, 128, 36, 48, 0};

    rst = 1'b0;
    apply(0, 0, 0, 0);
    i_bg_color = BG;
    i_video_can_read = 1'b1;
`ifdef VTG_TEST_PATTERN_EN
    i_pattern_sel = 1'b0;
`endif
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hs", 32'(o_hs), 32'd0);
    chk("rst_vs", 32'(o_vs), 32'd0);
    chk("rst_de", 32'(o_de), 32'd0);
    chk("rst_rgb", 32'(o_rgb), 32'd0);
    chk("rst_req", 32'(o_data_req), 32'd0);
    chk("rst_fs", 32'(o_frame_start), 32'd0);
    chk("rst_uf", 32'(o_underflow), 32'd0);
    rst = 1'b0;

    // Per-geometry frame statistics
    for (int t = 0; t < 8; t++) begin
      apply(int'(tbl[t].sx), int'(tbl[t].sy), int'(tbl[t].dh), int'(tbl[t].dv));
      wait_fs();
      wait_fs();
      count_frame(n_req, n_de, n_bg, n_hs, n_vs, n_blank);
      nm = $sformatf("v%0d", t);
      chk({nm, "_req"},   32'(n_req),   32'(tbl[t].req));
      chk({nm, "_de"},    32'(n_de),    32'(tbl[t].de));
      chk({nm, "_bgpix"}, 32'(n_bg),    32'(tbl[t].bgpix));
      chk({nm, "_hs"},    32'(n_hs),    32'(tbl[t].hs));
      chk({nm, "_vs"},    32'(n_vs),    32'(tbl[t].vs));
      chk({nm, "_blank"}, 32'(n_blank), 32'(tbl[t].blank));
    end

    // HS period and width
    hs_t1 = 0; hs_w = 0; hs_p = 0; found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!found && o_hs) begin found = 1; hs_t1 = cyc; end
      if (found && o_hs && (cyc - hs_t1) < 10) hs_w++;
      if (found && (cyc - hs_t1) > 10 && o_hs) begin hs_p = cyc - hs_t1; break; end
    end
    chk("hs_width", 32'(hs_w), 32'd3);
    chk("hs_period", 32'(hs_p), 32'd24);

    // Request timing and data alignment for the 4,2,6,3 window
    apply(4, 2, 6, 3);
    wait_fs();
    wait_fs();
    first = 0; found = 0;
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clk);
      if (o_data_req) begin found = 1; first = i; break; end
    end
    chk("first_req_offset", 32'(first), 32'd48);
    run = 1; stop = 0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (!stop && o_data_req) run++;
      else stop = 1;
      if (j == 3) chk("pre_win_bg", 32'(o_rgb), 32'(BG));
      if (j == 4) begin
        chk("win_de", 32'(o_de), 32'd1);
        chk("win_rgb", 32'(o_rgb), 32'(DATA_W'(cyc - 1)));
      end
    end
    chk("req_run", 32'(run), 32'd6);

    // Underflow on the second window pixel
    wait_fs();
    found = 0;
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clk);
      if (o_data_req) begin found = 1; break; end
    end
    chk("uf_req_seen", 32'(found), 32'd1);
    @(posedge clk); #1 i_video_can_read = 1'b0;
    @(posedge clk); #1 i_video_can_read = 1'b1;
    repeat (3) @(negedge clk);
    chk("uf_pix1_rgb", 32'(o_rgb), 32'(DATA_W'(cyc - 1)));
    chk("uf_before", 32'(o_underflow), 32'd0);
    @(negedge clk);
    chk("uf_pix2_rgb", 32'(o_rgb), 32'(BG));
    chk("uf_set", 32'(o_underflow), 32'd1);
    @(negedge clk);
    chk("uf_pix3_rgb", 32'(o_rgb), 32'(DATA_W'(cyc - 1)));
    drops = 0; found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (o_frame_start) begin found = 1; break; end
      if (!o_underflow) drops++;
    end
    chk("uf_sticky", 32'(drops), 32'd0);
    chk("uf_fs_seen", 32'(found), 32'd1);
    chk("uf_clear", 32'(o_underflow), 32'd0);

    // Width change mid-frame only takes effect next frame
    n_req = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i != 0) @(negedge clk);
      if (i == 100) i_disp_h = CNT_W'(2);
      n_req += int'(o_data_req);
    end
    chk("shadow_old_width", 32'(n_req), 32'd18);
    @(negedge clk);
    chk("shadow_fs", 32'(o_frame_start), 32'd1);
    count_frame(n_req, n_de, n_bg, n_hs, n_vs, n_blank);
    chk("shadow_new_width", 32'(n_req), 32'd6);

    // Asynchronous reset while a request is in flight
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (o_data_req) begin found = 1; break; end
    end
    chk("pre_rst_req", 32'(found), 32'd1);
    chk("pre_rst_de", 32'(o_de), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(o_data_req), 32'd0);
    chk("arst_de", 32'(o_de), 32'd0);
    chk("arst_rgb", 32'(o_rgb), 32'd0);
    chk("arst_hs", 32'(o_hs), 32'd0);
    chk("arst_vs", 32'(o_vs), 32'd0);
    chk("arst_fs", 32'(o_frame_start), 32'd0);
    chk("arst_uf", 32'(o_underflow), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (o_frame_start) begin first = i; break; end
    end
    chk("fs_after_rst", 32'(first), 32'd5);
    count_frame(n_req, n_de, n_bg, n_hs, n_vs, n_blank);
    chk("post_rst_req", 32'(n_req), 32'd0);
    chk("post_rst_de", 32'(n_de), 32'd128);
    @(negedge clk);
    chk("post_rst_fs2", 32'(o_frame_start), 32'd1);
    count_frame(n_req, n_de, n_bg, n_hs, n_vs, n_blank);
    chk("post_rst_req2", 32'(n_req), 32'd6);

`ifdef VTG_TEST_PATTERN_EN
    begin
      logic [23:0] bars [8];
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      i_pattern_sel = 1'b1;
      apply(0, 0, 16, 8);
      wait_fs();
      i_video_can_read = 1'b0;
      wait_fs();
      for (int c = 0; c < 16; c++) begin
        if (c != 0) @(negedge clk);
        chk($sformatf("bar_px%0d", c), 32'(o_rgb), 32'(bars[c / 2]));
      end
      @(negedge clk);
      wait_fs();
      count_frame(n_req, n_de, n_bg, n_hs, n_vs, n_blank);
      chk("pat_req", 32'(n_req), 32'd0);
      chk("pat_uf", 32'(o_underflow), 32'd0);
      i_video_can_read = 1'b1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
